// File: rtl/zap_tlb_pkg.sv
// Shared types and helpers for the TLB tag-store sequencing controller.
package zap_tlb_pkg;

   localparam int TLB_CNT_W = 16;

   typedef enum logic [1:0] {
      S_SCRUB = 2'd0,
      S_IDLE  = 2'd1,
      S_CMP   = 2'd2
   } tlb_ctrl_state_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [TLB_CNT_W-1:0] tlb_sat_inc(input logic [TLB_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/zap_mem_inv_block.sv
// Tag RAM with per-entry valid bits, registered read and a single-cycle
// whole-array invalidate.
module zap_mem_inv_block #(
   parameter int WIDTH = 52,
   parameter int DEPTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_inv,
   input  logic                     i_wen,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_rdav
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // A write in the same cycle as an invalidate survives the clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q <= '0;
         o_rdav  <= 1'b0;
      end else begin
         if (i_inv)
            valid_q <= '0;
         if (i_wen)
            valid_q[i_waddr] <= 1'b1;
         o_rdav <= valid_q[i_raddr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wen)
         mem_q[i_waddr] <= i_wdata;
      o_rdata <= mem_q[i_raddr];
   end

endmodule

// File: rtl/zap_tlb_tag_ctrl.sv
// Direct-mapped TLB/tag store controller: arbitrates invalidate, refill and
// lookup onto one tag RAM, runs the tag compare and keeps hit/miss statistics.
module zap_tlb_tag_ctrl
   import zap_tlb_pkg::*;
#(
   parameter int ENTRIES = 32,
   parameter int TAG_W   = 20,
   parameter int DATA_W  = 32
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_lkp_valid,
   input  logic [TAG_W+$clog2(ENTRIES)-1:0]  i_lkp_addr,
   output logic                              o_lkp_ready,
   output logic                              o_lkp_done,
   output logic                              o_lkp_hit,
   output logic [DATA_W-1:0]                 o_lkp_data,
   input  logic                              i_fill_valid,
   input  logic [TAG_W+$clog2(ENTRIES)-1:0]  i_fill_addr,
   input  logic [DATA_W-1:0]                 i_fill_data,
   output logic                              o_fill_ready,
   input  logic                              i_inv_req,
   output logic                              o_inv_ack,
   output logic [TLB_CNT_W-1:0]              o_hit_cnt,
   output logic [TLB_CNT_W-1:0]              o_miss_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int AW    = TAG_W + IDX_W;
   localparam int EW    = TAG_W + DATA_W;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } tlb_entry_t;

   tlb_ctrl_state_t  state, state_nxt;
   logic             mem_inv, mem_wen, mem_rdav;
   logic             inv_acc, lkp_acc, cmp, hit;
   tlb_entry_t       wr_entry, rd_entry;
   logic [TAG_W-1:0] tag_q;
   logic             inv_ack_q, done_q, hit_q;
   logic [DATA_W-1:0]    data_q;
   logic [TLB_CNT_W-1:0] hit_cnt_q, miss_cnt_q;

   zap_mem_inv_block #(
      .WIDTH (EW),
      .DEPTH (ENTRIES)
   ) u_mem (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inv   (mem_inv),
      .i_wen   (mem_wen),
      .i_waddr (i_fill_addr[IDX_W-1:0]),
      .i_wdata (wr_entry),
      .i_raddr (i_lkp_addr[IDX_W-1:0]),
      .o_rdata (rd_entry),
      .o_rdav  (mem_rdav)
   );

   always_comb begin
      state_nxt    = state;
      mem_inv      = 1'b0;
      mem_wen      = 1'b0;
      inv_acc      = 1'b0;
      lkp_acc      = 1'b0;
      cmp          = 1'b0;
      o_fill_ready = 1'b0;
      o_lkp_ready  = 1'b0;
      wr_entry     = '{tag: i_fill_addr[AW-1:IDX_W], data: i_fill_data};
      case (state)
         S_SCRUB: begin
            mem_inv   = 1'b1;
            state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (i_inv_req) begin
               mem_inv = 1'b1;
               inv_acc = 1'b1;
            end else begin
               o_fill_ready = 1'b1;
               if (i_fill_valid) begin
                  mem_wen = 1'b1;
               end else begin
                  o_lkp_ready = 1'b1;
                  if (i_lkp_valid) begin
                     lkp_acc   = 1'b1;
                     state_nxt = S_CMP;
                  end
               end
            end
         end
         S_CMP: begin
            cmp       = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_SCRUB;
      endcase
   end

   assign hit = mem_rdav && (rd_entry.tag == tag_q);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= S_SCRUB;
         tag_q      <= '0;
         inv_ack_q  <= 1'b0;
         done_q     <= 1'b0;
         hit_q      <= 1'b0;
         data_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state     <= state_nxt;
         inv_ack_q <= inv_acc;
         done_q    <= cmp;
         hit_q     <= cmp && hit;
         data_q    <= (cmp && hit) ? rd_entry.data : '0;
         if (lkp_acc)
            tag_q <= i_lkp_addr[AW-1:IDX_W];
         if (cmp) begin
            if (hit)
               hit_cnt_q <= tlb_sat_inc(hit_cnt_q);
            else
               miss_cnt_q <= tlb_sat_inc(miss_cnt_q);
         end
      end
   end

   assign o_inv_ack  = inv_ack_q;
   assign o_lkp_done = done_q;
   assign o_lkp_hit  = hit_q;
   assign o_lkp_data = data_q;
   assign o_hit_cnt  = hit_cnt_q;
   assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_zap_tlb_tag_ctrl.sv
// Randomized and directed bench for zap_tlb_tag_ctrl against a request-level
// model of the tag store (arrays of valid/tag/data plus expected timing).
module tb_zap_tlb_tag_ctrl;

   localparam int ENTRIES = 32;
   localparam int TAG_W   = 20;
   localparam int DATA_W  = 32;
   localparam int IDX_W   = 5;
   localparam int AW      = TAG_W + IDX_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              lkp_valid = 1'b0, fill_valid = 1'b0, inv_req = 1'b0;
   logic [AW-1:0]     lkp_addr = '0, fill_addr = '0;
   logic [DATA_W-1:0] fill_data = '0;
   logic              lkp_ready, lkp_done, lkp_hit, fill_ready, inv_ack;
   logic [DATA_W-1:0] lkp_data;
   logic [15:0]       hit_cnt, miss_cnt;

   zap_tlb_tag_ctrl #(
      .ENTRIES (ENTRIES),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_lkp_valid  (lkp_valid),
      .i_lkp_addr   (lkp_addr),
      .o_lkp_ready  (lkp_ready),
      .o_lkp_done   (lkp_done),
      .o_lkp_hit    (lkp_hit),
      .o_lkp_data   (lkp_data),
      .i_fill_valid (fill_valid),
      .i_fill_addr  (fill_addr),
      .i_fill_data  (fill_data),
      .o_fill_ready (fill_ready),
      .i_inv_req    (inv_req),
      .o_inv_ack    (inv_ack),
      .o_hit_cnt    (hit_cnt),
      .o_miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: contents of the store and expected event timing.
   bit                m_v    [ENTRIES];
   logic [TAG_W-1:0]  m_tag  [ENTRIES];
   logic [DATA_W-1:0] m_data [ENTRIES];
   int  m_hits, m_misses;
   int  cyc;
   bit  lk_pend;
   int  lk_acc_cyc, inv_acc_cyc, fill_acc_cyc;
   bit  exp_hit;
   logic [DATA_W-1:0] exp_data;

   // Outstanding requests held by the bench until accepted.
   bit                r_inv, r_fill, r_lkp;
   logic [AW-1:0]     r_faddr, r_laddr;
   logic [DATA_W-1:0] r_fdata;

   // Last observed lookup result.
   logic              obs_hit;
   logic [DATA_W-1:0] obs_data;

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
      m_hits = 0; m_misses = 0; cyc = 0; lk_pend = 1'b0;
      lk_acc_cyc = -10; inv_acc_cyc = -10; fill_acc_cyc = -10;
      r_inv = 1'b0; r_fill = 1'b0; r_lkp = 1'b0;
   endtask

   // One clock cycle, entered and left on a falling edge.
   task automatic step();
      bit done_e, idle;
      int idx;
      done_e = lk_pend && (cyc == lk_acc_cyc + 2);
      if (done_e) begin
         if (exp_hit) begin if (m_hits < 65535) m_hits++; end
         else begin if (m_misses < 65535) m_misses++; end
         lk_pend  = 1'b0;
         obs_hit  = lkp_hit;
         obs_data = lkp_data;
      end
      chk("done", lkp_done, done_e);
      chk("hit", lkp_hit, done_e && exp_hit);
      chk("data", lkp_data, (done_e && exp_hit) ? exp_data : '0);
      chk("inv_ack", inv_ack, cyc == inv_acc_cyc + 1);
      chk("hit_cnt", hit_cnt, 64'(m_hits));
      chk("miss_cnt", miss_cnt, 64'(m_misses));

      inv_req = r_inv;  fill_valid = r_fill; fill_addr = r_faddr; fill_data = r_fdata;
      lkp_valid = r_lkp; lkp_addr = r_laddr;
      #1;
      idle = (cyc >= 1) && !(lk_pend && cyc == lk_acc_cyc + 1);
      chk("fill_ready", fill_ready, idle && !r_inv);
      chk("lkp_ready", lkp_ready, idle && !r_inv && !r_fill);

      if (idle && r_inv) begin
         for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
         inv_acc_cyc = cyc; r_inv = 1'b0;
      end else if (idle && r_fill) begin
         idx = int'(r_faddr[IDX_W-1:0]);
         m_v[idx] = 1'b1; m_tag[idx] = r_faddr[AW-1:IDX_W]; m_data[idx] = r_fdata;
         fill_acc_cyc = cyc; r_fill = 1'b0;
      end else if (idle && r_lkp) begin
         idx = int'(r_laddr[IDX_W-1:0]);
         exp_hit  = m_v[idx] && (m_tag[idx] == r_laddr[AW-1:IDX_W]);
         exp_data = m_data[idx];
         lk_pend = 1'b1; lk_acc_cyc = cyc; r_lkp = 1'b0;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((r_inv || r_fill || r_lkp || lk_pend) && n < 60) begin
         step();
         n++;
      end
      if (n >= 60) chk("drain_timeout", 1'b1, 1'b0);
   endtask

   task automatic lookup(input logic [AW-1:0] a);
      r_lkp = 1'b1; r_laddr = a;
      drain();
   endtask

   task automatic fill(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
      r_fill = 1'b1; r_faddr = a; r_fdata = d;
      drain();
   endtask

   initial begin
      int ih, start;
      model_reset();
      r_faddr = '0; r_laddr = '0; r_fdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", lkp_done, 1'b0);
      chk("rst_lkp_ready", lkp_ready, 1'b0);
      chk("rst_fill_ready", fill_ready, 1'b0);
      chk("rst_hit_cnt", hit_cnt, 16'h0);
      rst = 1'b0;

      // First lookup right out of reset: accepted in the first IDLE cycle.
      lookup(25'h00040);
      chk("t1_acc_cycle", 64'(lk_acc_cyc), 64'd1);
      chk("t1_hit", obs_hit, 1'b0);
      chk("t1_miss_cnt", miss_cnt, 16'd1);

      // Fill then lookup back to back (fill wins priority, lookup next cycle).
      r_fill = 1'b1; r_faddr = 25'h12345; r_fdata = 32'hDEADBEEF;
      r_lkp = 1'b1;  r_laddr = 25'h12345;
      drain();
      chk("t2_lkp_after_fill", 64'(lk_acc_cyc - fill_acc_cyc), 64'd1);
      chk("t2_hit", obs_hit, 1'b1);
      chk("t2_data", obs_data, 32'hDEADBEEF);
      lookup(25'h22345);
      chk("t2_tag_mismatch", obs_hit, 1'b0);

      // Invalidate wipes a fresh fill.
      fill({20'hABCDE, 5'd3}, 32'h0BADF00D);
      ih = m_hits;
      r_inv = 1'b1;
      drain();
      lookup({20'hABCDE, 5'd3});
      chk("t3_hit_after_inv", obs_hit, 1'b0);
      chk("t3_hit_cnt_same", hit_cnt, 16'(ih));

      // All three requests together: inv, then fill, then lookup.
      r_inv = 1'b1;
      r_fill = 1'b1; r_faddr = {20'h00777, 5'd7}; r_fdata = 32'h7777_0007;
      r_lkp = 1'b1;  r_laddr = {20'h00777, 5'd9};
      start = cyc;
      drain();
      chk("t4_inv_at", 64'(inv_acc_cyc - start), 64'd0);
      chk("t4_fill_at", 64'(fill_acc_cyc - start), 64'd1);
      chk("t4_lkp_at", 64'(lk_acc_cyc - start), 64'd2);
      chk("t4_hit", obs_hit, 1'b0);
      lookup({20'h00777, 5'd7});
      chk("t4_fill_survived", obs_hit, 1'b1);

      // Random mix over a small tag/index space so hits are common.
      for (int i = 0; i < 500; i++) begin
         if (!r_inv && $urandom_range(0, 19) == 0) r_inv = 1'b1;
         if (!r_fill && $urandom_range(0, 2) == 0) begin
            r_fill = 1'b1;
            r_faddr = {20'($urandom_range(0, 3)), 5'($urandom_range(0, 7))};
            r_fdata = $urandom;
         end
         if (!r_lkp && $urandom_range(0, 1) == 0) begin
            r_lkp = 1'b1;
            r_laddr = {20'($urandom_range(0, 3)), 5'($urandom_range(0, 7))};
         end
         step();
      end
      drain();

      // Saturation of the hit counter.
      fill(25'h1F0A1, 32'hCAFE0001);
      force dut.hit_cnt_q = 16'hFFFE;
      #1;
      release dut.hit_cnt_q;
      m_hits = 65534;
      for (int i = 0; i < 3; i++) lookup(25'h1F0A1);
      chk("t5_hit_cnt_sat", hit_cnt, 16'hFFFF);

      // Reset while a compare is in flight.
      r_lkp = 1'b1; r_laddr = 25'h12345;
      start = 0;
      while (!lk_pend && start < 10) begin step(); start++; end
      chk("t6_lkp_accepted", lk_pend, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_done", lkp_done, 1'b0);
      chk("t6_hit_cnt", hit_cnt, 16'h0);
      chk("t6_miss_cnt", miss_cnt, 16'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_done_hold", lkp_done, 1'b0);
         chk("t6_data_hold", lkp_data, 32'h0);
      end
      model_reset();
      rst = 1'b0;
      lookup(25'h12345);
      chk("t6_acc_cycle", 64'(lk_acc_cyc), 64'd1);
      chk("t6_hit_after_reset", obs_hit, 1'b0);
      lookup(25'h1F0A1);
      chk("t6_hit2_after_reset", obs_hit, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
